dec_nto2n_scan: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder with enable.
- Two modes:
  - Direct: decodes the input address.
  - Scan: an internal prescaled counter steps the active output round-robin, e.g. Basys3 7-segment anode multiplexing.
- Successor to the team's combinational 2-to-4 decoders. Sits between board-level control logic and display or chip-select fan-out.

---
 rtl/dec_pkg.sv | 27 ++
 rtl/dec_prescaler.sv | 41 ++++
 rtl/dec_nto2n_scan.sv | 149 ++++++++++++++
 tb/tb_dec_nto2n_scan.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types and helpers for the N-to-2^N decoder family.
package dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int ONEHOT_MAX_W = 64;
    localparam int ONEHOT_IDX_W = 6;

    // Active-high one-hot of addr; all zeros when addr is outside 0..width-1.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned addr,
                                                        input int unsigned width);
        logic [ONEHOT_MAX_W-1:0] vec;
        vec = '0;
        if (addr < width && addr < ONEHOT_MAX_W) begin
            vec[addr[ONEHOT_IDX_W-1:0]] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/dec_prescaler.sv
// Free-running clock prescaler: a registered one-clock pulse every PRESCALE clocks while run is high.
module dec_prescaler #(
    parameter int PRESCALE = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("PRESCALE must be at least 1");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (run) begin
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/dec_nto2n_scan.sv
// Registered N-to-2^N one-hot decoder with direct and round-robin scan modes.
// Optional scan dead-time blanking is enabled by defining DEC_SCAN_BLANK_EN.
import dec_pkg::*;

module dec_nto2n_scan #(
    parameter int N            = 2,
    parameter int NUM_OUTS     = 4,
    parameter int PRESCALE     = 100000,
    parameter int ACTIVE_LOW   = 0,
    parameter int BLANK_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      a,
    output logic [(1<<N)-1:0] y,
    output logic [N-1:0]      sel,
    output logic              tick,
    output logic              err
);

    localparam int OUTS = 1 << N;
    localparam logic [N:0]      LIMIT     = (N+1)'(NUM_OUTS);
    localparam logic [N-1:0]    LAST_ADDR = N'(NUM_OUTS - 1);
    localparam logic [OUTS-1:0] Y_IDLE    = (ACTIVE_LOW != 0) ? '1 : '0;

    if (NUM_OUTS < 2 || NUM_OUTS > OUTS) begin : g_bad_num_outs
        $error("NUM_OUTS must lie in 2..2**N");
    end

    state_t          state_q, state_d;
    logic [N-1:0]    scan_q, scan_d;
    logic            pre_tick;
    logic            step;
    logic            blank;
    logic [OUTS-1:0] y_act, y_live, y_d;
    logic [N-1:0]    sel_d;
    logic            tick_d, err_d;

    always_comb begin
        state_d = ST_IDLE;
        if (en) begin
            case (mode)
                MODE_DIRECT: state_d = ST_DIRECT;
                MODE_SCAN:   state_d = ST_SCAN;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // The prescaler pulses one clock ahead so the step, tick and new y land on the same edge.
    dec_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_d != ST_SCAN),
        .run   (state_d == ST_SCAN),
        .tick  (pre_tick)
    );

    assign step = pre_tick && (state_q == ST_SCAN) && (state_d == ST_SCAN);

    always_comb begin
        scan_d = '0;
        sel_d  = sel;
        y_act  = '0;
        tick_d = 1'b0;
        err_d  = 1'b0;
        case (state_d)
            ST_DIRECT: begin
                sel_d = a;
                if ({1'b0, a} < LIMIT) begin
                    y_act = OUTS'(onehot(int'(a), NUM_OUTS));
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_SCAN: begin
                scan_d = scan_q;
                if (step) begin
                    scan_d = (scan_q == LAST_ADDR) ? '0 : scan_q + 1'b1;
                end
                sel_d  = scan_d;
                y_act  = OUTS'(onehot(int'(scan_d), NUM_OUTS));
                tick_d = step;
            end
            default: ;
        endcase
    end

`ifdef DEC_SCAN_BLANK_EN
    localparam int BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    logic [BLANK_W-1:0] blank_q, blank_d;

    if (BLANK_CYCLES >= PRESCALE) begin : g_bad_blank
        $error("BLANK_CYCLES must be less than PRESCALE");
    end

    // Dead time starts on the tick cycle itself and runs BLANK_CYCLES clocks.
    always_comb begin
        blank_d = '0;
        blank   = 1'b0;
        if (state_d == ST_SCAN) begin
            if (step && BLANK_CYCLES > 0) begin
                blank   = 1'b1;
                blank_d = BLANK_W'(BLANK_CYCLES - 1);
            end else if (blank_q != '0) begin
                blank   = 1'b1;
                blank_d = blank_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end
`else
    assign blank = 1'b0;
`endif

    assign y_live = blank ? '0 : y_act;
    assign y_d    = (ACTIVE_LOW != 0) ? ~y_live : y_live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            scan_q  <= '0;
            y       <= Y_IDLE;
            sel     <= '0;
            tick    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
            y       <= y_d;
            sel     <= sel_d;
            tick    <= tick_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_dec_nto2n_scan.sv
// Directed bench for dec_nto2n_scan: four instances with different parameters share one stimulus.
module tb_dec_nto2n_scan;

`ifdef DEC_SCAN_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       mode  = 1'b0;
    logic [1:0] a     = 2'd0;

    logic [3:0] y0, y1, y2, y3;
    logic [1:0] s0, s1, s2, s3;
    logic       t0, t1, t2, t3;
    logic       e0, e1, e2, e3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // dut0: reference build; dut1: active-low; dut2: three outputs; dut3: slower scan
    dec_nto2n_scan #(.N(2), .NUM_OUTS(4), .PRESCALE(4), .ACTIVE_LOW(0), .BLANK_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a),
        .y(y0), .sel(s0), .tick(t0), .err(e0));
    dec_nto2n_scan #(.N(2), .NUM_OUTS(4), .PRESCALE(4), .ACTIVE_LOW(1), .BLANK_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a),
        .y(y1), .sel(s1), .tick(t1), .err(e1));
    dec_nto2n_scan #(.N(2), .NUM_OUTS(3), .PRESCALE(4), .ACTIVE_LOW(0), .BLANK_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a),
        .y(y2), .sel(s2), .tick(t2), .err(e2));
    dec_nto2n_scan #(.N(2), .NUM_OUTS(4), .PRESCALE(8), .ACTIVE_LOW(0), .BLANK_CYCLES(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a),
        .y(y3), .sel(s3), .tick(t3), .err(e3));

    // Direct-mode vectors and their hand-computed results.
    logic [1:0] dir_a  [4] = '{2'd2, 2'd3, 2'd1, 2'd0};
    logic [3:0] dir_y0 [4] = '{4'b0100, 4'b1000, 4'b0010, 4'b0001};
    logic [3:0] dir_y1 [4] = '{4'b1011, 4'b0111, 4'b1101, 4'b1110};
    logic [3:0] dir_y2 [4] = '{4'b0100, 4'b0000, 4'b0010, 4'b0001};
    logic       dir_e2 [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    // k = clocks since entering scan (1 = first registered scan cycle), all builds use BLANK_CYCLES=2.
    function automatic int exp_sel(int k, int ps, int no);
        return ((k - 1) / ps) % no;
    endfunction

    function automatic logic exp_tick(int k, int ps);
        return (k > 1) && (((k - 1) % ps) == 0);
    endfunction

    function automatic logic [3:0] exp_y(int k, int ps, int no);
        if (BLANK_ON && k > 1 && ((k - 1) % ps) < 2) return 4'b0000;
        return 4'b0001 << exp_sel(k, ps, no);
    endfunction

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        n_vec++; if (y0 !== 4'b0000) begin n_bad++; $display("FAIL reset_y0 got %b want 0000", y0); end
        n_vec++; if (y1 !== 4'b1111) begin n_bad++; $display("FAIL reset_y1 got %b want 1111", y1); end
        n_vec++; if (s0 !== 2'd0) begin n_bad++; $display("FAIL reset_sel got %0d want 0", s0); end
        n_vec++; if (t0 !== 1'b0 || t3 !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b%b want 00", t0, t3); end
        n_vec++; if (e0 !== 1'b0 || e2 !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b%b want 00", e0, e2); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (y0 !== 4'b0000 || y1 !== 4'b1111) begin n_bad++; $display("FAIL idle_after_reset got %b/%b want 0000/1111", y0, y1); end
    endtask

    task automatic test_direct();
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; mode = 1'b0; a = dir_a[i];
            n_vec++; if (y0 !== (i == 0 ? 4'b0000 : dir_y0[i-1])) begin n_bad++; $display("FAIL direct_latency i=%0d got %b", i, y0); end
            @(negedge clk);
            n_vec++; if (y0 !== dir_y0[i]) begin n_bad++; $display("FAIL direct_y0 a=%0d got %b want %b", dir_a[i], y0, dir_y0[i]); end
            n_vec++; if (s0 !== dir_a[i]) begin n_bad++; $display("FAIL direct_sel a=%0d got %0d want %0d", dir_a[i], s0, dir_a[i]); end
            n_vec++; if (e0 !== 1'b0) begin n_bad++; $display("FAIL direct_err0 a=%0d got %b want 0", dir_a[i], e0); end
            n_vec++; if (y1 !== dir_y1[i]) begin n_bad++; $display("FAIL direct_y1 a=%0d got %b want %b", dir_a[i], y1, dir_y1[i]); end
            n_vec++; if (y2 !== dir_y2[i]) begin n_bad++; $display("FAIL range_y2 a=%0d got %b want %b", dir_a[i], y2, dir_y2[i]); end
            n_vec++; if (e2 !== dir_e2[i]) begin n_bad++; $display("FAIL range_err2 a=%0d got %b want %b", dir_a[i], e2, dir_e2[i]); end
            n_vec++; if (s2 !== dir_a[i]) begin n_bad++; $display("FAIL range_sel2 a=%0d got %0d want %0d", dir_a[i], s2, dir_a[i]); end
            n_vec++; if (t0 !== 1'b0) begin n_bad++; $display("FAIL direct_tick a=%0d got %b want 0", dir_a[i], t0); end
        end
    endtask

    task automatic test_idle();
        en = 1'b1; mode = 1'b0; a = 2'd3;
        @(negedge clk);
        n_vec++; if (e2 !== 1'b1) begin n_bad++; $display("FAIL idle_pre_err2 got %b want 1", e2); end
        en = 1'b0;
        @(negedge clk);
        n_vec++; if (y0 !== 4'b0000 || y1 !== 4'b1111) begin n_bad++; $display("FAIL idle_y got %b/%b want 0000/1111", y0, y1); end
        n_vec++; if (e2 !== 1'b0) begin n_bad++; $display("FAIL idle_err2 got %b want 0", e2); end
        n_vec++; if (s2 !== 2'd3 || s0 !== 2'd3) begin n_bad++; $display("FAIL idle_sel_hold got %0d/%0d want 3/3", s0, s2); end
    endtask

    task automatic test_scan_wrap();
        en = 1'b1; mode = 1'b0; a = 2'd3;
        @(negedge clk);
        mode = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            n_vec++; if (s0 !== 2'(exp_sel(k, 4, 4))) begin n_bad++; $display("FAIL scan_sel0 k=%0d got %0d want %0d", k, s0, exp_sel(k, 4, 4)); end
            n_vec++; if (t0 !== exp_tick(k, 4)) begin n_bad++; $display("FAIL scan_tick0 k=%0d got %b want %b", k, t0, exp_tick(k, 4)); end
            n_vec++; if (y0 !== exp_y(k, 4, 4)) begin n_bad++; $display("FAIL scan_y0 k=%0d got %b want %b", k, y0, exp_y(k, 4, 4)); end
            n_vec++; if (y1 !== ~exp_y(k, 4, 4)) begin n_bad++; $display("FAIL scan_y1 k=%0d got %b want %b", k, y1, ~exp_y(k, 4, 4)); end
            n_vec++; if (e0 !== 1'b0) begin n_bad++; $display("FAIL scan_err0 k=%0d got %b want 0", k, e0); end
            n_vec++; if (s2 !== 2'(exp_sel(k, 4, 3))) begin n_bad++; $display("FAIL scan3_sel k=%0d got %0d want %0d", k, s2, exp_sel(k, 4, 3)); end
            n_vec++; if (y2 !== exp_y(k, 4, 3)) begin n_bad++; $display("FAIL scan3_y k=%0d got %b want %b", k, y2, exp_y(k, 4, 3)); end
            n_vec++; if (s3 !== 2'(exp_sel(k, 8, 4))) begin n_bad++; $display("FAIL scan8_sel k=%0d got %0d want %0d", k, s3, exp_sel(k, 8, 4)); end
            n_vec++; if (t3 !== exp_tick(k, 8)) begin n_bad++; $display("FAIL scan8_tick k=%0d got %b want %b", k, t3, exp_tick(k, 8)); end
            n_vec++; if (y3 !== exp_y(k, 8, 4)) begin n_bad++; $display("FAIL blank_y3 k=%0d got %b want %b", k, y3, exp_y(k, 8, 4)); end
        end
    endtask

    task automatic test_disable_mid_scan();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1; mode = 1'b1;
        for (int k = 1; k <= 9; k++) @(negedge clk);
        n_vec++; if (s0 !== 2'd2) begin n_bad++; $display("FAIL dis_pre_sel got %0d want 2", s0); end
        en = 1'b0;
        @(negedge clk);
        n_vec++; if (y0 !== 4'b0000) begin n_bad++; $display("FAIL dis_y got %b want 0000", y0); end
        n_vec++; if (s0 !== 2'd2) begin n_bad++; $display("FAIL dis_sel_hold got %0d want 2", s0); end
        n_vec++; if (t0 !== 1'b0) begin n_bad++; $display("FAIL dis_tick got %b want 0", t0); end
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_vec++; if (s0 !== 2'(exp_sel(k, 4, 4))) begin n_bad++; $display("FAIL restart_sel k=%0d got %0d want %0d", k, s0, exp_sel(k, 4, 4)); end
            n_vec++; if (t0 !== exp_tick(k, 4)) begin n_bad++; $display("FAIL restart_tick k=%0d got %b want %b", k, t0, exp_tick(k, 4)); end
            n_vec++; if (y0 !== exp_y(k, 4, 4)) begin n_bad++; $display("FAIL restart_y k=%0d got %b want %b", k, y0, exp_y(k, 4, 4)); end
        end
    endtask

    task automatic test_reset_mid_scan();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1; mode = 1'b1;
        for (int k = 1; k <= 13; k++) @(negedge clk);
        n_vec++; if (s0 !== 2'd3) begin n_bad++; $display("FAIL rst_pre_sel got %0d want 3", s0); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (y0 !== 4'b0000 || y1 !== 4'b1111) begin n_bad++; $display("FAIL rst_async_y got %b/%b want 0000/1111", y0, y1); end
        n_vec++; if (s0 !== 2'd0 || t0 !== 1'b0) begin n_bad++; $display("FAIL rst_async_sel_tick got %0d/%b want 0/0", s0, t0); end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_vec++; if (s0 !== 2'(exp_sel(k, 4, 4))) begin n_bad++; $display("FAIL rst_restart_sel k=%0d got %0d want %0d", k, s0, exp_sel(k, 4, 4)); end
            n_vec++; if (t0 !== exp_tick(k, 4)) begin n_bad++; $display("FAIL rst_restart_tick k=%0d got %b want %b", k, t0, exp_tick(k, 4)); end
            n_vec++; if (y0 !== exp_y(k, 4, 4)) begin n_bad++; $display("FAIL rst_restart_y k=%0d got %b want %b", k, y0, exp_y(k, 4, 4)); end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_idle();
        test_scan_wrap();
        test_disable_mid_scan();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
